// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder (one full-adder cell, registered carry)
// with valid/ready handshakes on the operand and result sides.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, h_s, h_c, fa_s, fa_c;
  // full adder built from two half-adder cells plus an OR for the carry
  assign h_s  = sa_q[0] ^ sb_q[0];
  assign h_c  = sa_q[0] & sb_q[0];
  assign fa_s = h_s ^ c_q;
  assign fa_c = h_c | (h_s & c_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = in_valid ? RUN : IDLE;
      RUN:     state_d = (cnt_q == LAST) ? DONE : RUN;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
  end
  always_comb begin
    sa_d  = sa_q;
    sb_d  = sb_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    if (state_q == IDLE && in_valid) begin
      sa_d  = a;
      sb_d  = b;
      c_d   = cin;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      sa_d  = sa_q >> 1;
      sb_d  = sb_q >> 1;
      c_d   = fa_c;
      sum_d = {fa_s, sum_q[WIDTH-1:1]};
      cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q  <= '0;
      sb_q  <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      sum_q <= sum_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
    end
  end
  assign sum  = sum_q;
  assign cout = c_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks on WIDTH=8, exhaustive WIDTH=2, and a
// randomized WIDTH=16 run scored against plain a+b+cin arithmetic.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int got16 = 0;
  logic       iv8 = 1'b0, cin8 = 1'b0, or8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, cout8, busy8;
  logic [7:0] sum8;
  logic       iv2 = 1'b0, cin2 = 1'b0, or2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       in_ready2, out_valid2, cout2, busy2;
  logic [1:0] sum2;
  logic        iv16 = 1'b0, cin16 = 1'b0, or16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready16, out_valid16, cout16, busy16;
  logic [15:0] sum16;
  logic [16:0] q16[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(in_ready8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(or8), .sum(sum8), .cout(cout8), .busy(busy8));
  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(in_ready2), .a(a2), .b(b2), .cin(cin2),
    .out_valid(out_valid2), .out_ready(or2), .sum(sum2), .cout(cout2), .busy(busy2));
  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(in_ready16), .a(a16), .b(b16), .cin(cin16),
    .out_valid(out_valid16), .out_ready(or16), .sum(sum16), .cout(cout16), .busy(busy16));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // accept at the edge after this call's first negedge; result due WIDTH edges later
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic [8:0] exp);
    @(negedge clk);
    chk("in_ready8", in_ready8, 1);
    iv8 = 1'b1; a8 = ta; b8 = tb; cin8 = tc;
    @(negedge clk);
    iv8 = 1'b0;
    chk("busy8_run", busy8, 1);
    for (int i = 1; i < 8; i++) @(negedge clk);
    chk("early_valid8", out_valid8, 0);
    @(negedge clk);
    chk("out_valid8", out_valid8, 1);
    chk("result8", {cout8, sum8}, exp);
  endtask

  task automatic release8(input logic [8:0] exp);
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk("in_ready8_after", in_ready8, 1);
    chk("out_valid8_after", out_valid8, 0);
    chk("hold8_idle", {cout8, sum8}, exp);
  endtask

  // result-side monitor: random backpressure, pops the model on each transfer
  always @(negedge clk) begin
    or16 = 1'($urandom_range(0, 1));
    if (out_valid16 && or16) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dup16: result %0h with no pending operands", {cout16, sum16});
      end else begin
        chk("result16", {cout16, sum16}, q16.pop_front());
        got16++;
      end
    end
  end

  initial begin
    logic [2:0] e2;
    @(negedge clk);
    chk("rst_in_ready", in_ready8, 1);
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_result", {cout8, sum8}, 0);
    rst_n = 1'b1;
    run8(8'h5A, 8'h33, 1'b0, 9'h08D);
    release8(9'h08D);
    run8(8'hFF, 8'h01, 1'b0, 9'h100);
    release8(9'h100);
    run8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    release8(9'h1FF);
    run8(8'h12, 8'h34, 1'b0, 9'h046);
    for (int i = 0; i < 5; i++) begin
      iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_valid", out_valid8, 1);
      chk("bp_in_ready", in_ready8, 0);
      chk("bp_stable", {cout8, sum8}, 9'h046);
    end
    iv8 = 1'b0;
    release8(9'h046);
    @(negedge clk);
    chk("bp_ignored", busy8, 0);
    iv8 = 1'b1; a8 = 8'hA5; b8 = 8'h3C; cin8 = 1'b0;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", {cout8, sum8}, 0);
    chk("arst_out_valid", out_valid8, 0);
    chk("arst_busy", busy8, 0);
    chk("arst_in_ready", in_ready8, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h01, 8'h01, 1'b0, 9'h002);
    release8(9'h002);
    for (int x = 0; x < 32; x++) begin
      @(negedge clk);
      iv2 = 1'b1; a2 = 2'(x >> 3); b2 = 2'(x >> 1); cin2 = 1'(x);
      e2 = 3'(a2) + 3'(b2) + 3'(cin2);
      @(negedge clk);
      iv2 = 1'b0;
      @(negedge clk);
      chk("early_valid2", out_valid2, 0);
      @(negedge clk);
      chk("out_valid2", out_valid2, 1);
      chk("result2", {cout2, sum2}, e2);
      or2 = 1'b1;
      @(negedge clk);
      or2 = 1'b0;
    end
    for (int n = 0; n < 1000;) begin
      @(negedge clk);
      if ($urandom_range(0, 3) != 0) begin
        iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom_range(0, 1));
        if (in_ready16) begin
          q16.push_back({1'b0, a16} + {1'b0, b16} + 17'(cin16));
          n++;
        end
      end else iv16 = 1'b0;
    end
    @(negedge clk);
    iv16 = 1'b0;
    for (int t = 0; t < 500 && q16.size() != 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain16", q16.size(), 0);
    chk("count16", got16, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
